// File: rtl/mips_branch_pkg.sv
// rtl/mips_branch_pkg.sv - shared constants and FSM encoding for the branch/PC stage
package mips_branch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SLOT = 1'b1
    } br_state_t;

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - combinational branch/jump target select (jr > j > beq/bne)
module branch_target
    import mips_branch_pkg::*;
(
    input  logic        i_is_j,
    input  logic        i_is_jr,
    input  logic [31:0] i_id_pc_plus4,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_jaddr,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_target
);

    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    // Word offset: sign-extend then shift left by two; the add wraps modulo 2^32
    assign w_br_offset = {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_br_target = i_id_pc_plus4 + w_br_offset;
    assign w_j_target  = {i_id_pc_plus4[31:28], i_jaddr, 2'b00};

    always_comb begin
        o_target = w_br_target;
        if (i_is_jr) begin
            o_target = i_rs_data;
        end else if (i_is_j) begin
            o_target = w_j_target;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - PC register, branch resolution and stats; BRANCH_DELAY_SLOT_EN enables delay-slot FSM
module branch_pc_unit
    import mips_branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             id_valid,
    input  logic             is_beq,
    input  logic             is_bne,
    input  logic             is_j,
    input  logic             is_jr,
    input  logic             equal,
    input  logic [31:0]      id_pc_plus4,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jaddr,
    input  logic [31:0]      rs_data,
    output logic [31:0]      pc,
    output logic             redirect,
    output logic             flush_if_id,
    output logic             slot_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_taken_count;
    logic [31:0]      w_target;
    logic             w_cf;
    logic             w_in_run;
    logic             w_resolve;
    logic             w_taken;

    branch_target u_branch_target (
        .i_is_j        (is_j),
        .i_is_jr       (is_jr),
        .i_id_pc_plus4 (id_pc_plus4),
        .i_imm16       (imm16),
        .i_jaddr       (jaddr),
        .i_rs_data     (rs_data),
        .o_target      (w_target)
    );

    assign w_cf = is_beq | is_bne | is_j | is_jr;

`ifdef BRANCH_DELAY_SLOT_EN
    br_state_t r_state;
    br_state_t w_state_nxt;
    logic      r_slot_err;

    assign w_in_run = (r_state == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_taken) w_state_nxt = ST_SLOT;
            ST_SLOT: if (!stall && id_valid) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_slot_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_SLOT && id_valid && !stall && w_cf) begin
                r_slot_err <= 1'b1;
            end
        end
    end

    assign slot_err    = r_slot_err;
    assign flush_if_id = 1'b0;
`else
    assign w_in_run    = 1'b1;
    assign slot_err    = 1'b0;
    assign flush_if_id = w_taken;
`endif

    // rst_n gating keeps redirect/flush quiet while reset is held
    assign w_resolve = rst_n & id_valid & ~stall & w_cf & w_in_run;
    assign w_taken   = w_resolve & (is_jr | is_j | (is_beq & equal) | (is_bne & ~equal));
    assign redirect  = w_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else if (!stall) begin
            r_pc <= w_taken ? w_target : r_pc + PC_INC;
            if (w_resolve && r_br_count != '1) begin
                r_br_count <= r_br_count + CNT_ONE;
            end
            if (w_taken && r_taken_count != '1) begin
                r_taken_count <= r_taken_count + CNT_ONE;
            end
        end
    end

    assign pc          = r_pc;
    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - directed self-checking bench for branch_pc_unit
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, id_valid;
    logic        is_beq, is_bne, is_j, is_jr, equal;
    logic [31:0] id_pc_plus4, rs_data;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] pc;
    logic        redirect, flush_if_id, slot_err;
    logic [3:0]  br_count, taken_count;

    int checks = 0;
    int errors = 0;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FLUSH_ON_TAKEN = 1'b0;
`else
    localparam logic FLUSH_ON_TAKEN = 1'b1;
`endif

    always #5 clk = ~clk;

    branch_pc_unit #(.RESET_PC(32'h0), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .id_valid    (id_valid),
        .is_beq      (is_beq),
        .is_bne      (is_bne),
        .is_j        (is_j),
        .is_jr       (is_jr),
        .equal       (equal),
        .id_pc_plus4 (id_pc_plus4),
        .imm16       (imm16),
        .jaddr       (jaddr),
        .rs_data     (rs_data),
        .pc          (pc),
        .redirect    (redirect),
        .flush_if_id (flush_if_id),
        .slot_err    (slot_err),
        .br_count    (br_count),
        .taken_count (taken_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        id_valid = 1'b0; is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jr = 1'b0;
        equal = 1'b0; stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        clear_ctl();
        id_valid = 1'b1;
        tick();
    endtask

    initial begin
        clear_ctl();
        id_pc_plus4 = 32'h0; imm16 = 16'h0; jaddr = 26'h0; rs_data = 32'h0;
        rst_n = 1'b0; stall = 1'b1;
        repeat (2) tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_br", {28'h0, br_count}, 32'h0);
        chk("rst_tk", {28'h0, taken_count}, 32'h0);
        chk("rst_redirect", {31'h0, redirect}, 32'h0);
        chk("rst_slot_err", {31'h0, slot_err}, 32'h0);

        rst_n = 1'b1; stall = 1'b0;
        tick();
        chk("first_pc", pc, 32'h4);

        // beq taken, negative offset
        clear_ctl();
        id_valid = 1'b1; is_beq = 1'b1; equal = 1'b1;
        id_pc_plus4 = 32'h100; imm16 = 16'hFFFE;
        #1;
        chk("beq_redirect", {31'h0, redirect}, 32'h1);
        chk("beq_flush", {31'h0, flush_if_id}, {31'h0, FLUSH_ON_TAKEN});
        tick();
        chk("beq_pc", pc, 32'hF8);
        chk("beq_tk", {28'h0, taken_count}, 32'h1);
        chk("beq_br", {28'h0, br_count}, 32'h1);
        nop();
        chk("nop_pc", pc, 32'hFC);

        // j to 0x1FC, then nop lands on 0x200
        clear_ctl();
        id_valid = 1'b1; is_j = 1'b1; id_pc_plus4 = 32'h0; jaddr = 26'h7F;
        tick();
        chk("j1_pc", pc, 32'h1FC);
        nop();
        chk("pre_bne_pc", pc, 32'h200);

        // bne not taken
        clear_ctl();
        id_valid = 1'b1; is_bne = 1'b1; equal = 1'b1; imm16 = 16'h0040;
        #1;
        chk("bne_redirect", {31'h0, redirect}, 32'h0);
        chk("bne_flush", {31'h0, flush_if_id}, 32'h0);
        tick();
        chk("bne_pc", pc, 32'h204);
        chk("bne_br", {28'h0, br_count}, 32'h3);
        chk("bne_tk", {28'h0, taken_count}, 32'h2);

        // jr wins over j
        clear_ctl();
        id_valid = 1'b1; is_jr = 1'b1; is_j = 1'b1; rs_data = 32'h0040_0010; jaddr = 26'h123;
        tick();
        chk("jr_pc", pc, 32'h0040_0010);
        nop();

        // j alone keeps upper PC nibble
        clear_ctl();
        id_valid = 1'b1; is_j = 1'b1; id_pc_plus4 = 32'hA000_0004; jaddr = 26'h3FF_FFFF;
        tick();
        chk("j2_pc", pc, 32'hAFFF_FFFC);
        chk("j2_br", {28'h0, br_count}, 32'h5);
        chk("j2_tk", {28'h0, taken_count}, 32'h4);
        nop();
        chk("j2_nop_pc", pc, 32'hB000_0000);

        // stalled taken beq for three cycles
        clear_ctl();
        id_valid = 1'b1; is_beq = 1'b1; equal = 1'b1; id_pc_plus4 = 32'h1000; imm16 = 16'h0004;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_redirect", {31'h0, redirect}, 32'h0);
            tick();
            chk("stall_pc", pc, 32'hB000_0000);
        end
        chk("stall_br", {28'h0, br_count}, 32'h5);
        chk("stall_tk", {28'h0, taken_count}, 32'h4);
        stall = 1'b0;
        #1;
        chk("unstall_redirect", {31'h0, redirect}, 32'h1);
        tick();
        chk("unstall_pc", pc, 32'h1010);
        chk("unstall_tk", {28'h0, taken_count}, 32'h5);
        clear_ctl();
        #1;
        chk("redirect_once", {31'h0, redirect}, 32'h0);
        nop();

        // 20 taken branches saturate both 4-bit counters
        for (int i = 0; i < 20; i++) begin
            clear_ctl();
            id_valid = 1'b1; is_beq = 1'b1; equal = 1'b1; id_pc_plus4 = 32'h2000; imm16 = 16'h0;
            tick();
            nop();
        end
        chk("sat_br", {28'h0, br_count}, 32'hF);
        chk("sat_tk", {28'h0, taken_count}, 32'hF);
        chk("sat_pc", pc, 32'h2004);

        // PC wrap
        clear_ctl();
        id_valid = 1'b1; is_j = 1'b1; id_pc_plus4 = 32'hF000_0000; jaddr = 26'h3FF_FFFF;
        tick();
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        clear_ctl();
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_br_hold", {28'h0, br_count}, 32'hF);

`ifdef BRANCH_DELAY_SLOT_EN
        // still in SLOT (bubble held it); a branch here is an error, not a redirect
        clear_ctl();
        id_valid = 1'b1; is_beq = 1'b1; equal = 1'b1; id_pc_plus4 = 32'h3000; imm16 = 16'h0010;
        #1;
        chk("slot_redirect", {31'h0, redirect}, 32'h0);
        tick();
        chk("slot_pc", pc, 32'h4);
        chk("slot_err_set", {31'h0, slot_err}, 32'h1);
        nop();
        nop();
        chk("slot_err_sticky", {31'h0, slot_err}, 32'h1);
`else
        chk("slot_err_tied", {31'h0, slot_err}, 32'h0);
`endif

        // reset clears counters and flags
        clear_ctl();
        rst_n = 1'b0;
        tick();
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_br", {28'h0, br_count}, 32'h0);
        chk("rst2_slot_err", {31'h0, slot_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
